// File: rtl/serial_add_pkg.sv
// Shared constants and FSM state type for the serial nibble adder.
package serial_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic COUT
);

  assign SUM  = A ^ B ^ CIN;
  assign COUT = (A & B) | (CIN & (A ^ B));

endmodule

// File: rtl/nibble_adder.sv
// 4-bit ripple adder slice built from full_adder cells; index 3 is the LSB.
module nibble_adder (
  input  logic [0:3] A,
  input  logic [0:3] B,
  input  logic       CIN,
  output logic [0:3] SUM,
  output logic       COUT
);

  // c[i+1] feeds bit i, so the ripple runs from index 3 up to index 0
  logic [0:4] c;

  assign c[4] = CIN;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .A    (A[i]),
      .B    (B[i]),
      .CIN  (c[i+1]),
      .SUM  (SUM[i]),
      .COUT (c[i])
    );
  end

  assign COUT = c[0];

endmodule

// File: rtl/serial_add_controller.sv
// Serial adder: one shared nibble_adder processes one nibble per cycle, LSB first.
// Optional OVF output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_controller
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [0:4*NIBBLES-1]      A,
  input  logic [0:4*NIBBLES-1]      B,
  input  logic                      CIN,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [0:4*NIBBLES-1]      SUM,
  output logic                      COUT
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                      OVF
`endif
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [0:W-1]    a_q, a_d, b_q, b_d;
  logic [0:W-1]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  logic [0:3]      a_nib, b_nib, nib_sum;
  logic            nib_cout;
  logic            last_nib;

  // Operand nibble for the current count; count 0 is the rightmost (LSB) slice
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (cnt_q == CW'(k)) begin
        a_nib = a_q[W-NIBBLE_W-NIBBLE_W*k +: NIBBLE_W];
        b_nib = b_q[W-NIBBLE_W-NIBBLE_W*k +: NIBBLE_W];
      end
    end
  end

  nibble_adder u_nibble_adder (
    .A    (a_nib),
    .B    (b_nib),
    .CIN  (carry_q),
    .SUM  (nib_sum),
    .COUT (nib_cout)
  );

  assign last_nib = (cnt_q == CW'(NIBBLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < NIBBLES; k++) begin
          if (cnt_q == CW'(k)) begin
            sum_d[W-NIBBLE_W-NIBBLE_W*k +: NIBBLE_W] = nib_sum;
          end
        end
        carry_d = nib_cout;
        if (last_nib) begin
          cout_d  = nib_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // Carry into the MSB is recovered from the MSB sum bit of the final slice
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && last_nib) begin
      ovf_d = (a_nib[0] ^ b_nib[0] ^ nib_sum[0]) ^ nib_cout;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`else
  // Overflow tracking compiled out; the SUM/COUT datapath is unchanged.
`endif

endmodule

// File: tb/tb_serial_add_controller.sv
// Self-checking bench for serial_add_controller (NIBBLES=4); checks OVF when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_controller;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:15] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] sum;
  logic        cout;
  logic        ovf;

  always #5 clk = ~clk;

  serial_add_controller #(.NIBBLES(NIB)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .A         (a),
    .B         (b),
    .CIN       (cin),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .SUM       (sum),
    .COUT      (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .OVF       (ovf)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got=result expected=empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      check({name, ".sum"}, {16'h0, sum}, {16'h0, e.s});
      check({name, ".cout"}, {31'h0, cout}, {31'h0, e.c});
`ifdef SERIAL_ADD_OVF_EN
      check({name, ".ovf"}, {31'h0, ovf}, {31'h0, e.o});
`endif
    end
  endtask

  // One full request/response with the consumer ready once the result appears
  task automatic run_txn(input string name, input vec_t v);
    exp_t e;
    int   lat;
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) tick;
    check({name, ".ready"}, {31'h0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    e.s = v.s; e.c = v.c; e.o = v.o;
    sb.push_back(e);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    check({name, ".latency"}, lat, NIB + 1);
    check_pop(name);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({name, ".vld_drop"}, {31'h0, out_valid}, 32'd0);
  endtask

  function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    vec_t        v;
    logic [16:0] full;
    full  = {1'b0, va} + {1'b0, vb} + {16'h0, vc};
    v.a   = va; v.b = vb; v.cin = vc;
    v.s   = full[15:0];
    v.c   = full[16];
    v.o   = (va[15] == vb[15]) && (full[15] != va[15]);
    return v;
  endfunction

  vec_t v;
  exp_t e1, e2;
  int   acc_edge[2];
  int   nacc, nres;
  bit   accepting;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    vecs.push_back('{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1))));
    end

    tick; tick;
    check("rst.in_ready", {31'h0, in_ready}, 32'd1);
    check("rst.out_valid", {31'h0, out_valid}, 32'd0);
    check("rst.sum", {16'h0, sum}, 32'd0);
    check("rst.cout", {31'h0, cout}, 32'd0);
    rst = 1'b0;
    tick;

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result must hold and a new request must be ignored
    run_txn("pre_bp", mk(16'h0001, 16'h0002, 1'b0));
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    e1.s = 16'h3333; e1.c = 1'b0; e1.o = 1'b0;
    sb.push_back(e1);
    for (int k = 0; k < 20 && !out_valid; k++) tick;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("bp.out_valid", {31'h0, out_valid}, 32'd1);
      check("bp.in_ready", {31'h0, in_ready}, 32'd0);
      check("bp.sum", {16'h0, sum}, 32'h3333);
      check("bp.cout", {31'h0, cout}, 32'd0);
      tick;
    end
    check_pop("bp");
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bp.after_vld", {31'h0, out_valid}, 32'd0);
    check("bp.not_taken", {31'h0, in_ready}, 32'd1);

    // Reset asserted during the second RUN cycle
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst.in_ready", {31'h0, in_ready}, 32'd1);
    check("midrst.out_valid", {31'h0, out_valid}, 32'd0);
    check("midrst.sum", {16'h0, sum}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick;
      check("midrst.no_pulse", {31'h0, out_valid}, 32'd0);
    end
    run_txn("post_rst", '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0});

    // Back-to-back with IN_VALID and OUT_READY held high
    out_ready = 1'b1;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    e1.s = 16'h5555; e1.c = 1'b0; e1.o = 1'b0;
    e2.s = 16'h0001; e2.c = 1'b1; e2.o = 1'b0;
    sb.push_back(e1);
    nacc = 0; nres = 0;
    acc_edge[0] = 0; acc_edge[1] = 0;
    for (int cyc = 0; cyc < 40 && nres < 2; cyc++) begin
      accepting = in_ready && in_valid;
      tick;
      if (accepting && nacc < 2) begin
        acc_edge[nacc] = cyc;
        nacc++;
        if (nacc == 1) begin
          a = 16'hFFFF; b = 16'h0001; cin = 1'b1;
          sb.push_back(e2);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check_pop("b2b");
        nres++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.results", nres, 2);
    check("b2b.accepts", nacc, 2);
    check("b2b.interval", acc_edge[1] - acc_edge[0], NIB + 2);
    check("b2b.sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_controller.md
SERIAL_ADD_CONTROLLER -- requirements
Module: serial_add_controller

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit slices (W = 4*NIBBLES, NIBBLES >= 1).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port IN_VALID, input, 1, operand request valid.
REQ-005 SHALL have port IN_READY, output, 1, controller can accept an operand request.
REQ-006 SHALL have ports A and B, input, [0:W-1], operands; index W-1 is the LSB and index 0 is the MSB.
REQ-007 SHALL have port CIN, input, 1, carry into the least significant slice.
REQ-008 SHALL have port OUT_VALID, output, 1, result valid.
REQ-009 SHALL have port OUT_READY, input, 1, consumer accepts the result.
REQ-010 SHALL have port SUM, output, [0:W-1], result with the same bit ordering as A and B.
REQ-011 SHALL have port COUT, output, 1, carry out of the most significant slice.

Function
REQ-012 SHALL use one shared 4-bit adder slice, one nibble per cycle, LSB nibble (A[W-4:W-1]) first.
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
- IDLE: IN_READY=1; IN_VALID=1 -> latch A, B and CIN, clear the nibble counter, go to RUN.
- RUN: each cycle, add the current nibbles with the registered carry, write the nibble into SUM, register the carry-out, and increment the counter; after nibble NIBBLES-1, go to DONE.
- DONE: OUT_VALID=1; OUT_READY=1 -> go to IDLE.
REQ-014 SHALL assert IN_READY only in IDLE; IN_VALID in other states is ignored and the latched operands are not disturbed.
REQ-015 SHALL give a latency of NIBBLES+1 cycles from the accepting edge to OUT_VALID, which is 5 cycles for the default.
REQ-016 SHALL hold SUM, COUT and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0, for an unbounded time.
REQ-017 SHALL accept the next request no earlier than the cycle after a DONE handshake; the minimum issue interval is NIBBLES+2 cycles.
REQ-018 SHALL wrap modulo 2^W, with the carry out of the final nibble reported on COUT.
REQ-019 SHALL, when NIBBLES=1, go from RUN to DONE after one cycle.

Reset
REQ-020 SHALL, while RST=1 at a clock edge, go to IDLE, clear the nibble counter, and set OUT_VALID=0, SUM=0 and COUT=0; IN_READY is 1 from the first cycle after reset.
REQ-021 SHALL, on RST during RUN or DONE, abort the operation with no OUT_VALID pulse; RST has priority over every other input.

Configuration
REQ-022 SHALL, with macro SERIAL_ADD_OVF_EN defined, add output OVF (1 bit).
- OVF = signed two's-complement overflow, i.e. the carry into the MSB XOR the carry out of the MSB.
- OVF is valid with OUT_VALID and is reset to 0.
- Without the macro, the OVF port and its logic are absent and all other behaviour is identical.

Structure
REQ-023 SHALL place the constant NIBBLE_W=4 and the FSM state typedef (IDLE/RUN/DONE) in shared package serial_add_pkg.
REQ-024 SHALL implement the 4-bit slice as sub-module nibble_adder (ports A[0:3], B[0:3], CIN, SUM[0:3], COUT), built from the existing full_adder cells; the controller instantiates exactly one nibble_adder.

Verification
REQ-025 SHALL cover the basic add: A=0x1234, B=0x0FFF, CIN=0 -> SUM=0x2233, COUT=0, with OUT_VALID 5 cycles after acceptance.
REQ-026 SHALL cover full carry ripple: A=0xFFFF, B=0x0001, CIN=0 -> SUM=0x0000, COUT=1; also A=0xFFFF, B=0x0000, CIN=1 -> SUM=0x0000, COUT=1.
REQ-027 SHALL cover backpressure: hold OUT_READY=0 for 10 cycles -> SUM and COUT stable and IN_READY=0 throughout; a new IN_VALID in that window is not accepted.
REQ-028 SHALL cover reset mid-operation: assert RST in the 2nd RUN cycle -> next cycle IN_READY=1, OUT_VALID=0, SUM=0; the next request 0x0001+0x0001 gives 0x0002.
REQ-029 SHALL cover back-to-back requests: issue two requests with IN_VALID held high -> the second is accepted exactly NIBBLES+2 cycles after the first and both results are correct.
REQ-030 SHALL, with SERIAL_ADD_OVF_EN defined, check A=0x7FFF, B=0x0001 -> SUM=0x8000, OVF=1, COUT=0; and A=0xFFFF, B=0x0001 -> OVF=0.
